// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and encodings for the pipeline hazard controller and its sub-blocks.
package pipe_ctrl_pkg;

  localparam int ADDR_W_DEF   = 12;
  localparam int REG_ID_W_DEF = 3;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    RET_POP  = 2'd1,
    RET_WAIT = 2'd2,
    RET_JMP  = 2'd3
  } state_t;

  localparam logic [1:0] PC_SRC_PLUS1  = 2'b00;
  localparam logic [1:0] PC_SRC_TARGET = 2'b01;
  localparam logic [1:0] PC_SRC_STACK  = 2'b10;

endpackage

// File: rtl/pipeline_hazard_controller_hazard_detect.sv
// Combinational load-use and flag-use hazard compare between the ID and EX stages.
module hazard_detect #(
  parameter int REG_ID_W = pipe_ctrl_pkg::REG_ID_W_DEF
) (
  input  logic [REG_ID_W-1:0] id_rs,
  input  logic [REG_ID_W-1:0] id_rt,
  input  logic                id_uses_rs,
  input  logic                id_uses_rt,
  input  logic                id_branch,
  input  logic                ex_mem_read,
  input  logic [REG_ID_W-1:0] ex_rd,
  input  logic                ex_sets_flags,
  output logic                stall_lu,
  output logic                stall_flag
);

  logic rs_match;
  logic rt_match;

  assign rs_match   = id_uses_rs && (id_rs == ex_rd);
  assign rt_match   = id_uses_rt && (id_rt == ex_rd);
  assign stall_lu   = ex_mem_read && (rs_match || rt_match);
  // A branch cannot resolve until the flag-setting instruction ahead of it has written C/Z.
  assign stall_flag = id_branch && ex_sets_flags;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline stall/flush/PC-source controller with a multi-cycle return sequence.
// Optional HAZARD_PERF_CNT_EN adds saturating stall and flush counters.
module pipeline_hazard_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int REG_ID_W = REG_ID_W_DEF,
  parameter int RET_LAT  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_ID_W-1:0] id_rs,
  input  logic [REG_ID_W-1:0] id_rt,
  input  logic                id_uses_rs,
  input  logic                id_uses_rt,
  input  logic                id_jump,
  input  logic                id_branch,
  input  logic                id_cond_true,
  input  logic                id_call,
  input  logic                id_ret,
  input  logic [ADDR_W-1:0]   id_target,
  input  logic [ADDR_W-1:0]   stack_out,
  input  logic                ex_mem_read,
  input  logic [REG_ID_W-1:0] ex_rd,
  input  logic                ex_sets_flags,
  output logic                pc_ld,
  output logic [1:0]          pc_sel,
  output logic [ADDR_W-1:0]   next_pc_redirect,
  output logic                pr1_ld,
  output logic                pr1_flush,
  output logic                pr2_bubble,
  output logic                push_stack,
  output logic                pop_stack,
  output logic                busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0]         stall_cnt,
  output logic [15:0]         flush_cnt
`endif
);

  localparam int RET_CNT_W = 2;

  state_t               state;
  state_t               next_state;
  logic [RET_CNT_W-1:0] ret_cnt;
  logic [RET_CNT_W-1:0] ret_cnt_nxt;
  logic                 stall_lu;
  logic                 stall_flag;
  logic                 stall;

  hazard_detect #(
    .REG_ID_W (REG_ID_W)
  ) u_hazard_detect (
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rs    (id_uses_rs),
    .id_uses_rt    (id_uses_rt),
    .id_branch     (id_branch),
    .ex_mem_read   (ex_mem_read),
    .ex_rd         (ex_rd),
    .ex_sets_flags (ex_sets_flags),
    .stall_lu      (stall_lu),
    .stall_flag    (stall_flag)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      ret_cnt <= '0;
    end else begin
      state   <= next_state;
      ret_cnt <= ret_cnt_nxt;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    next_state  = state;
    ret_cnt_nxt = ret_cnt;
    stall       = 1'b0;
    pc_ld       = 1'b0;
    pc_sel      = PC_SRC_PLUS1;
    pr1_ld      = 1'b0;
    pr1_flush   = 1'b0;
    pr2_bubble  = 1'b0;
    push_stack  = 1'b0;
    pop_stack   = 1'b0;
    busy        = (state != RUN);

    unique case (state)
      RUN: begin
        if (stall_lu || stall_flag) begin
          stall      = 1'b1;
          pr2_bubble = 1'b1;
        end else if (id_ret) begin
          pr1_flush  = 1'b1;
          pop_stack  = 1'b1;
          next_state = RET_POP;
        end else if (id_jump || id_call || (id_branch && id_cond_true)) begin
          pc_sel     = PC_SRC_TARGET;
          pc_ld      = 1'b1;
          pr1_flush  = 1'b1;
          push_stack = id_call;
        end else begin
          pc_ld  = 1'b1;
          pr1_ld = 1'b1;
        end
      end
      RET_POP: begin
        pr1_flush   = 1'b1;
        ret_cnt_nxt = RET_CNT_W'(RET_LAT - 1);
        next_state  = (RET_LAT == 1) ? RET_JMP : RET_WAIT;
      end
      RET_WAIT: begin
        pr1_flush   = 1'b1;
        ret_cnt_nxt = ret_cnt - 1'b1;
        if (ret_cnt == RET_CNT_W'(1)) next_state = RET_JMP;
      end
      RET_JMP: begin
        pc_sel     = PC_SRC_STACK;
        pc_ld      = 1'b1;
        pr1_flush  = 1'b1;
        next_state = RUN;
      end
      default: next_state = RUN;
    endcase

    // Reset forces the pipeline quiet regardless of what the FSM would decode.
    if (rst) begin
      stall      = 1'b0;
      pc_ld      = 1'b0;
      pc_sel     = PC_SRC_PLUS1;
      pr1_ld     = 1'b0;
      pr1_flush  = 1'b1;
      pr2_bubble = 1'b1;
      push_stack = 1'b0;
      pop_stack  = 1'b0;
      busy       = 1'b0;
    end
  end

  assign next_pc_redirect = (state == RET_JMP) ? stack_out : id_target;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != 16'hFFFF))     stall_cnt <= stall_cnt + 16'd1;
      if (pr1_flush && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: RUN-state vector table plus return/reset sequences.
module tb_pipeline_hazard_controller;
  import pipe_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic [2:0]  id_rs, id_rt, ex_rd;
  logic        id_uses_rs, id_uses_rt, id_jump, id_branch, id_cond_true, id_call, id_ret;
  logic [11:0] id_target, stack_out;
  logic        ex_mem_read, ex_sets_flags;
  logic        pc_ld, pr1_ld, pr1_flush, pr2_bubble, push_stack, pop_stack, busy;
  logic [1:0]  pc_sel;
  logic [11:0] next_pc_redirect;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  pipeline_hazard_controller #(
    .ADDR_W   (12),
    .REG_ID_W (3),
    .RET_LAT  (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .id_rs            (id_rs),
    .id_rt            (id_rt),
    .id_uses_rs       (id_uses_rs),
    .id_uses_rt       (id_uses_rt),
    .id_jump          (id_jump),
    .id_branch        (id_branch),
    .id_cond_true     (id_cond_true),
    .id_call          (id_call),
    .id_ret           (id_ret),
    .id_target        (id_target),
    .stack_out        (stack_out),
    .ex_mem_read      (ex_mem_read),
    .ex_rd            (ex_rd),
    .ex_sets_flags    (ex_sets_flags),
    .pc_ld            (pc_ld),
    .pc_sel           (pc_sel),
    .next_pc_redirect (next_pc_redirect),
    .pr1_ld           (pr1_ld),
    .pr1_flush        (pr1_flush),
    .pr2_bubble       (pr2_bubble),
    .push_stack       (push_stack),
    .pop_stack        (pop_stack),
    .busy             (busy)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt        (stall_cnt),
    .flush_cnt        (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  rs, rt;
    logic        uses_rs, uses_rt, jump, branch, cond, call, mem_read;
    logic [2:0]  rd;
    logic        sets_flags;
    logic [11:0] target;
    logic        e_pc_ld;
    logic [1:0]  e_pc_sel;
    logic        e_pr1_ld, e_flush, e_bubble, e_push;
  } vec_t;

  vec_t vecs[14];

  // Output bundle order: {pc_ld, pc_sel[1:0], pr1_ld, pr1_flush, pr2_bubble, push, pop, busy}
  localparam logic [8:0] EXP_RESET = 9'b0_00_0_1_1_0_0_0;
  localparam logic [8:0] EXP_ISSUE = 9'b1_00_1_0_0_0_0_0;
  localparam logic [8:0] EXP_STALL = 9'b0_00_0_0_1_0_0_0;
  localparam logic [8:0] EXP_JUMP  = 9'b1_01_0_1_0_0_0_0;
  localparam logic [8:0] EXP_POP   = 9'b0_00_0_1_0_0_1_0;
  localparam logic [8:0] EXP_WAIT  = 9'b0_00_0_1_0_0_0_1;
  localparam logic [8:0] EXP_RJMP  = 9'b1_10_0_1_0_0_0_1;

  function automatic logic [8:0] outs();
    return {pc_ld, pc_sel, pr1_ld, pr1_flush, pr2_bubble, push_stack, pop_stack, busy};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_rd = '0;
    id_uses_rs = 0; id_uses_rt = 0; id_jump = 0; id_branch = 0; id_cond_true = 0;
    id_call = 0; id_ret = 0; ex_mem_read = 0; ex_sets_flags = 0;
    id_target = 12'h777; stack_out = 12'h043;
  endtask

  task automatic apply(input vec_t v);
    id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.uses_rs; id_uses_rt = v.uses_rt;
    id_jump = v.jump; id_branch = v.branch; id_cond_true = v.cond; id_call = v.call;
    id_ret = 0; ex_mem_read = v.mem_read; ex_rd = v.rd; ex_sets_flags = v.sets_flags;
    id_target = v.target;
  endtask

  initial begin
    //          name               rs    rt    urs urt j  b  c  cl mr rd    sf tgt      pcld sel   pr1 fl bub push
    vecs[0]  = '{"normal",         3'd1, 3'd2, 1,  1,  0, 0, 0, 0, 0, 3'd4, 0, 12'h010, 1, 2'b00, 1, 0, 0, 0};
    vecs[1]  = '{"lu_rs",          3'd3, 3'd0, 1,  0,  0, 0, 0, 0, 1, 3'd3, 0, 12'h020, 0, 2'b00, 0, 0, 1, 0};
    vecs[2]  = '{"lu_rt",          3'd1, 3'd5, 1,  1,  0, 0, 0, 0, 1, 3'd5, 0, 12'h030, 0, 2'b00, 0, 0, 1, 0};
    vecs[3]  = '{"lu_not_used",    3'd3, 3'd3, 0,  0,  0, 0, 0, 0, 1, 3'd3, 0, 12'h040, 1, 2'b00, 1, 0, 0, 0};
    vecs[4]  = '{"lu_diff_reg",    3'd2, 3'd6, 1,  1,  0, 0, 0, 0, 1, 3'd3, 0, 12'h050, 1, 2'b00, 1, 0, 0, 0};
    vecs[5]  = '{"same_reg_noload",3'd3, 3'd0, 1,  0,  0, 0, 0, 0, 0, 3'd3, 0, 12'h060, 1, 2'b00, 1, 0, 0, 0};
    vecs[6]  = '{"lu_over_branch", 3'd3, 3'd0, 1,  0,  0, 1, 1, 0, 1, 3'd3, 0, 12'h0A5, 0, 2'b00, 0, 0, 1, 0};
    vecs[7]  = '{"flag_use",       3'd0, 3'd0, 0,  0,  0, 1, 1, 0, 0, 3'd0, 1, 12'h0A5, 0, 2'b00, 0, 0, 1, 0};
    vecs[8]  = '{"flag_not_taken", 3'd0, 3'd0, 0,  0,  0, 1, 0, 0, 0, 3'd0, 1, 12'h0A5, 0, 2'b00, 0, 0, 1, 0};
    vecs[9]  = '{"jump_flags_ok",  3'd0, 3'd0, 0,  0,  1, 0, 0, 0, 0, 3'd0, 1, 12'h2AB, 1, 2'b01, 0, 1, 0, 0};
    vecs[10] = '{"jump_max",       3'd0, 3'd0, 0,  0,  1, 0, 0, 0, 0, 3'd0, 0, 12'hFFF, 1, 2'b01, 0, 1, 0, 0};
    vecs[11] = '{"call",           3'd0, 3'd0, 0,  0,  0, 0, 0, 1, 0, 3'd0, 0, 12'h100, 1, 2'b01, 0, 1, 0, 1};
    vecs[12] = '{"branch_taken",   3'd0, 3'd0, 0,  0,  0, 1, 1, 0, 0, 3'd0, 0, 12'h0A5, 1, 2'b01, 0, 1, 0, 0};
    vecs[13] = '{"branch_not_tkn", 3'd0, 3'd0, 0,  0,  0, 1, 0, 0, 0, 3'd0, 0, 12'h0A5, 1, 2'b00, 1, 0, 0, 0};

    clear_inputs();
    rst    = 1'b1;
    id_ret = 1'b1;
    id_jump = 1'b1;
    @(negedge clk); #2;
    check("reset_outputs", 32'(outs()), 32'(EXP_RESET));
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    #2;
    check("post_reset_issue", 32'(outs()), 32'(EXP_ISSUE));

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      apply(vecs[i]);
      #2;
      check({"vec_", vecs[i].name}, 32'(outs()),
            32'({vecs[i].e_pc_ld, vecs[i].e_pc_sel, vecs[i].e_pr1_ld, vecs[i].e_flush,
                 vecs[i].e_bubble, vecs[i].e_push, 1'b0, 1'b0}));
      check({"redirect_", vecs[i].name}, 32'(next_pc_redirect), 32'(vecs[i].target));
    end

    // Load-use stall lasts one cycle once the load leaves EX.
    @(negedge clk); clear_inputs();
    ex_mem_read = 1; ex_rd = 3'd3; id_rs = 3'd3; id_uses_rs = 1; #2;
    check("lu_seq_stall", 32'(outs()), 32'(EXP_STALL));
    @(negedge clk); ex_mem_read = 0; #2;
    check("lu_seq_issue", 32'(outs()), 32'(EXP_ISSUE));

    // Flag stall, then the branch resolves taken.
    @(negedge clk); clear_inputs();
    id_branch = 1; id_cond_true = 1; ex_sets_flags = 1; id_target = 12'h0A5; #2;
    check("flag_seq_stall", 32'(outs()), 32'(EXP_STALL));
    @(negedge clk); ex_sets_flags = 0; #2;
    check("flag_seq_taken", 32'(outs()), 32'(EXP_JUMP));
    check("flag_seq_redirect", 32'(next_pc_redirect), 32'h0A5);

    // Return with RET_LAT=2.
    @(negedge clk); clear_inputs(); id_ret = 1; #2;
    check("ret_c0_pop", 32'(outs()), 32'(EXP_POP));
    @(negedge clk); id_ret = 0; #2;
    check("ret_c1_hold", 32'(outs()), 32'(EXP_WAIT));
    @(negedge clk); #2;
    check("ret_c2_hold", 32'(outs()), 32'(EXP_WAIT));
    @(negedge clk); #2;
    check("ret_c3_jump", 32'(outs()), 32'(EXP_RJMP));
    check("ret_c3_redirect", 32'(next_pc_redirect), 32'h043);
    @(negedge clk); #2;
    check("ret_c4_run", 32'(outs()), 32'(EXP_ISSUE));

    // Reset while in RET_WAIT discards the pending return.
    @(negedge clk); clear_inputs(); id_ret = 1;
    @(negedge clk); id_ret = 0;
    @(negedge clk); #2;
    check("rstret_in_wait", 32'(outs()), 32'(EXP_WAIT));
    rst = 1; #1;
    check("rstret_forced", 32'(outs()), 32'(EXP_RESET));
    @(negedge clk); rst = 0; #2;
    check("rstret_run", 32'(outs()), 32'(EXP_ISSUE));
    @(negedge clk); #2;
    check("rstret_no_jump", 32'(outs()), 32'(EXP_ISSUE));

`ifdef HAZARD_PERF_CNT_EN
    @(negedge clk); clear_inputs(); rst = 1;
    @(negedge clk); rst = 0; #2;
    check("cnt_rst_stall", 32'(stall_cnt), 32'd0);
    check("cnt_rst_flush", 32'(flush_cnt), 32'd0);
    ex_mem_read = 1; ex_rd = 3'd3; id_rs = 3'd3; id_uses_rs = 1;
    @(negedge clk); clear_inputs(); id_jump = 1; id_target = 12'h100; #2;
    check("cnt_stall_one", 32'(stall_cnt), 32'd1);
    check("cnt_flush_zero", 32'(flush_cnt), 32'd0);
    @(negedge clk); clear_inputs(); id_branch = 1; id_cond_true = 0; #2;
    check("cnt_flush_one", 32'(flush_cnt), 32'd1);
    @(negedge clk); clear_inputs(); #2;
    check("cnt_nt_stall", 32'(stall_cnt), 32'd1);
    check("cnt_nt_flush", 32'(flush_cnt), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Sequences the 5-stage pipeline: PC fetch, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Detects load-use and flag-use hazards and drives stall, bubble and flush controls.
- Selects the next-PC source (plus1, branch/jump target, stack) and the stack push/pop strobes.
- Sits beside the forwarding unit. Consumes ID- and EX-stage decode fields; drives the PC register load, the pipeline-register enables and the PC source mux.

Parameters:
- ADDR_W, 12, PC/address width.
- REG_ID_W, 3, register-file index width.
- RET_LAT, 1, cycles between stack pop and stack_out valid (legal: 1..3).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- id_rs  in  REG_ID_W  ID-stage source register 1.
- id_rt  in  REG_ID_W  ID-stage source register 2 (already muxed).
- id_uses_rs  in  1  ID instruction reads id_rs.
- id_uses_rt  in  1  ID instruction reads id_rt.
- id_jump  in  1  unconditional jump in ID.
- id_branch  in  1  conditional branch in ID.
- id_cond_true  in  1  branch condition evaluated from the current C/Z flags.
- id_call  in  1  call (jump + push) in ID.
- id_ret  in  1  return in ID.
- id_target  in  ADDR_W  jump/branch/call target.
- stack_out  in  ADDR_W  top-of-stack address.
- ex_mem_read  in  1  EX instruction is a load.
- ex_rd  in  REG_ID_W  EX destination register.
- ex_sets_flags  in  1  EX instruction updates C/Z.
- pc_ld  out  1  PC register load enable.
- pc_sel  out  2  next-PC source: 00 plus1, 01 id_target, 10 stack_out.
- next_pc_redirect  out  ADDR_W  selected redirect address (id_target or stack_out).
- pr1_ld  out  1  IF/ID load enable.
- pr1_flush  out  1  IF/ID clears to NOP on next edge.
- pr2_bubble  out  1  ID/EX control fields cleared (RF_write_en, MEM_read, MEM_write, flag load) on next edge.
- push_stack  out  1  one-cycle push strobe.
- pop_stack  out  1  one-cycle pop strobe.
- busy  out  1  FSM not in RUN.

Behaviour:
- Reset: state=RUN, ret_cnt=0. While rst=1: pc_ld=0, pr1_ld=0, pr1_flush=1, pr2_bubble=1, pc_sel=00, push_stack=0, pop_stack=0, busy=0.
- FSM states: RUN, RET_POP, RET_WAIT, RET_JMP.
- Outputs are combinational from state and inputs. Only state and ret_cnt are registered.
- RUN, priority order (first match wins):
  1. Load-use: ex_mem_read && ((id_uses_rs && id_rs==ex_rd) || (id_uses_rt && id_rt==ex_rd)). Outputs: pc_ld=0, pr1_ld=0, pr2_bubble=1. Exactly 1 stall cycle per hazard. No control action is taken this cycle even if the ID instruction is a branch.
  2. Flag-use: id_branch && ex_sets_flags. Same stall outputs as load-use. The branch re-evaluates next cycle.
  3. id_ret: pr1_flush=1, pc_ld=0, pop_stack=1; next state RET_POP.
  4. id_jump, id_call, or (id_branch && id_cond_true): pc_sel=01, pc_ld=1, pr1_flush=1. id_call also asserts push_stack=1 (pushes PC+1 of the call). Single-cycle redirect, 1-cycle penalty.
  5. Otherwise: pc_sel=00, pc_ld=1, pr1_ld=1, all strobes 0.
- RET_POP: pc_ld=0, pr1_flush=1, ret_cnt<=RET_LAT-1.
  - If RET_LAT==1, next state RET_JMP.
  - Otherwise next state RET_WAIT.
- RET_WAIT: pc_ld=0, pr1_flush=1, ret_cnt decrements; on ret_cnt==1, next state RET_JMP.
- RET_JMP: pc_sel=10, pc_ld=1, pr1_flush=1; next state RUN.
- Return penalty: RET_LAT+2 cycles.
- Strobes: push_stack and pop_stack never assert together, and each asserts for exactly one cycle per instruction.
- Flushed ID slot: decodes as NOP, so a redirect never repeats.
- busy: 1 in every state except RUN.
- Reset mid-return: FSM returns to RUN, ret_cnt=0, and the pending pop target is discarded.
- Decode contract: id_* control bits are mutually exclusive. If several are asserted, the priority order above applies.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds output ports stall_cnt[15:0] and flush_cnt[15:0].
  - stall_cnt increments on every load-use or flag-use stall cycle.
  - flush_cnt increments on every cycle with pr1_flush=1 outside reset.
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: no ports or registers; behaviour otherwise identical.

Decomposition:
- Package pipe_ctrl_pkg:
  - state enum (RUN, RET_POP, RET_WAIT, RET_JMP);
  - pc_sel encodings PC_SRC_PLUS1=2'b00, PC_SRC_TARGET=2'b01, PC_SRC_STACK=2'b10;
  - ADDR_W and REG_ID_W defaults.
- One combinational sub-module, hazard_detect: load-use and flag-use compare, outputs stall_lu and stall_flag. FSM and output decode remain in the top.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=3, id_rs=3, id_uses_rs=1 -> exactly one cycle of pc_ld=0, pr1_ld=0, pr2_bubble=1, then normal issue.
- Flag stall then taken branch: id_branch=1, id_cond_true=1, ex_sets_flags=1 -> one stall cycle; next cycle pc_sel=01, next_pc_redirect=12'h0A5, pr1_flush=1.
- Call: id_call=1, id_target=12'h100 -> same cycle push_stack=1, pc_sel=01, pc_ld=1, pr1_flush=1, no pop.
- Return, RET_LAT=2, stack_out=12'h043: pop_stack pulses in cycle 0; pc_ld=0 cycles 1–2; cycle 3 pc_sel=10 with redirect 12'h043; busy high cycles 1–3.
- Reset during RET_WAIT -> next cycle state RUN, busy=0, no RET_JMP redirect issued.
- Not-taken branch (id_branch=1, id_cond_true=0, no hazard) -> pc_sel=00, pr1_ld=1, no flush; with HAZARD_PERF_CNT_EN, counters are unchanged.
